// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between two requesters.
//               Port 0 is the CPU control path (fetch/operand/store), port 1
//               is the I/O / DMA engine. Each access is captured in IDLE,
//               held on the memory strobes for MEM_LAT cycles (ACCESS), and
//               acknowledged with a one-cycle pulse (DONE).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : ADDR_W  - memory address width
//               DATA_W  - memory data width
//               MEM_LAT - cycles rd/wr are held asserted (1..15)
// Ports       : mclk, mrst         - clock, synchronous active-high reset
//               req0/we0/addr0/wdata0 -> ack0/rdata0 : port 0 (CPU)
//               req1/we1/addr1/wdata1 -> ack1/rdata1 : port 1 (DMA)
//               mem_rd/mem_wr/mem_addr/mem_wdata, mem_rdata : memory side
//               cpu_stall - high while port 0 waits for its acknowledge
//               busy      - high whenever the arbiter is not idle
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties;
//               otherwise port 0 has fixed priority.
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall,
  output logic              busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       grant;   // port currently being served
  logic       we_cap;  // captured direction of the current access
  logic       pick;    // port that wins arbitration this cycle
  logic       we_sel;

`ifdef MEM_ARB_RR_EN
  logic       last_grant;

  // On a tie the port that was not served last time wins; reset leaves
  // last_grant = 1 so port 0 takes the first tie.
  always_comb begin
    pick = ~req0;
    if (req0 && req1) begin
      pick = ~last_grant;
    end
  end
`else
  // Fixed priority: port 1 only when port 0 is not requesting.
  always_comb begin
    pick = ~req0;
  end
`endif

  assign we_sel = pick ? we1 : we0;

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      grant     <= 1'b0;
      we_cap    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant     <= pick;
            we_cap    <= we_sel;
            mem_addr  <= pick ? addr1 : addr0;
            mem_wdata <= pick ? wdata1 : wdata0;
            mem_rd    <= ~we_sel;
            mem_wr    <= we_sel;
            cnt       <= LAT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Last strobe cycle: memory data is valid now, so latch it and
            // raise the ack that will be visible during DONE.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!we_cap) begin
              if (grant) begin
                rdata1 <= mem_rdata;
              end else begin
                rdata0 <= mem_rdata;
              end
            end
            ack0  <= ~grant;
            ack1  <= grant;
            state <= DONE;
          end
        end
        DONE: begin
`ifdef MEM_ARB_RR_EN
          last_grant <= grant;
`endif
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the sequencer is released in the ack cycle itself.
  assign cpu_stall = req0 & ~ack0;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main memory between two requesters: port 0 (CPU control path: fetch, operand read, store) and port 1 (I/O / DMA engine).
- Sequences every access over a fixed memory latency and returns a one-cycle acknowledge.
- Drives a CPU stall line that holds the control-path sequencer while port 0 is waiting.
- Sits between ctrlpath/datapath and the memory model.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, cycles the memory needs with rd/wr held asserted (legal range 1..15)

Ports:
mclk  in  1  clock, all state updates on rising edge
mrst  in  1  synchronous active-high reset
req0  in  1  port 0 (CPU) request
we0  in  1  port 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 access complete, one-cycle pulse
rdata0  out  DATA_W  port 0 read data
req1  in  1  port 1 (DMA) request
we1  in  1  port 1 write enable
addr1  in  ADDR_W  port 1 address
wdata1  in  DATA_W  port 1 write data
ack1  out  1  port 1 access complete, one-cycle pulse
rdata1  out  DATA_W  port 1 read data
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle
cpu_stall  out  1  high while port 0 waits, feeds the sequencer enable
busy  out  1  state != IDLE

Behaviour:
- Reset (mrst=1 at edge): state=IDLE; ack0, ack1, mem_rd, mem_wr, busy = 0; mem_addr, mem_wdata, rdata0, rdata1 = 0; latency counter = 0; last_grant = 1, so port 0 wins the first tie. Reset mid-access aborts the access immediately and raises no ack.
- FSM:
  - IDLE: if any req is high, pick the winner, capture its we/addr/wdata into internal registers, load counter = MEM_LAT, go to ACCESS. Otherwise stay.
  - ACCESS: mem_addr/mem_wdata come from the captured registers. mem_rd = ~we_cap, mem_wr = we_cap, both held for exactly MEM_LAT cycles. The counter decrements each cycle. When counter==1, latch mem_rdata into the winner's rdata register on reads, then go to DONE.
  - DONE: pulse the winner's ack for one cycle, update last_grant, go to IDLE.
- Latency: a request first seen in IDLE at cycle 0 gets ack at cycle MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Handshake:
  - A requester holds req, we, addr, wdata stable until it sees ack.
  - Changes during ACCESS are ignored because the values are captured in IDLE.
  - req still high in the cycle after ack is treated as a new request.
  - rdataN is valid in the ack cycle and holds until the next read completes on that port.
  - A write leaves rdataN unchanged.
- Arbitration (base build): fixed priority, port 0 always wins when both request. Port 1 is served only when req0 is low in IDLE.
- cpu_stall = req0 & ~ack0 (combinational). It is high during IDLE/ACCESS/DONE for port 0 and during port 1 service while req0 is pending, and low in the port 0 ack cycle.
- Simultaneous events:
  - A new req arriving during ACCESS/DONE waits for IDLE.
  - Both reqs arriving in the same IDLE cycle: arbitration rule decides.
  - Only one ack is ever high in a cycle.
- Writes do not affect the non-winning port.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin. When both req are high in IDLE, grant the port != last_grant. A single requester is always granted. After reset, port 0 wins the first tie.
- Undefined: fixed priority as described, and last_grant is unused.

Test Plan:
- Single read: memory preloaded M[0x010]=0x1234, MEM_LAT=2, req0=1 we0=0 addr0=0x010 at cycle 0 -> mem_rd high cycles 1–2, ack0 pulse at cycle 3, rdata0=0x1234, cpu_stall high cycles 0–2 and low at cycle 3.
- Write then read on port 1: write 0xBEEF to 0x7FF, then read 0x7FF -> mem_wr high exactly 2 cycles with mem_addr=0x7FF, second ack1 returns rdata1=0xBEEF, ack0 never asserts.
- Contention, base build: req0 and req1 both asserted at cycle 0 and kept asserted -> port 0 served at every arbitration and ack1 never fires while req0 stays high. With MEM_ARB_RR_EN: grants alternate 0,1,0,1 with acks at cycles 3, 7, 11, 15.
- Input change mid-access: addr0 switched from 0x010 to 0x020 during ACCESS -> mem_addr stays 0x010 and rdata0 = M[0x010].
- Reset mid-access: mrst=1 in the second ACCESS cycle -> the next cycle shows IDLE with all strobes and acks low, no ack for the aborted request, and a new req1 is served normally afterwards.
- MEM_LAT=1 back-to-back: req0 held high for 3 accesses -> ack0 at cycles 2, 5, 8.
